slow_to_fast_capture: RTL and testbench
=======================================

// Module: slow_to_fast_capture
// PURPOSE
//  Fast-domain receiver for WIDTH-bit sample words launched on slow_clk rising edges.
//  - Runs on fast_clk only. Treats slow_clk_in as an asynchronous data input.
//  - Detects each slow rising edge through a 2-flop synchronizer.
//  - Waits SETTLE_CYCLES, samples d_slow, and presents the word on a valid/ready interface.
//  - Sits between the ADC/trigger front end and the Nios-facing sample path. Flags overrun and loss of slow clock.
// PARAMETERS
//  WIDTH          12    sample width in bits
//  SETTLE_CYCLES  2     fast cycles between detected edge and capture (>=1)
//  TIMEOUT_CYCLES 64    fast cycles without a slow edge before slow_clk_lost asserts
// PORTS
//  fast_clk       in   1      sole clock, all flops on rising edge
//  reset          in   1      asynchronous, active-high
//  slow_clk_in    in   1      slow clock, sampled as async data
//  d_slow         in   WIDTH  sample word, changes only just after slow_clk_in rises
//  q              out  WIDTH  captured word
//  q_valid        out  1      q holds an unconsumed word
//  q_ready        in   1      consumer accepts q when q_valid && q_ready
//  clr_overrun    in   1      synchronous clear of overrun
//  overrun        out  1      sticky: a capture overwrote an unconsumed word
//  slow_clk_lost  out  1      no slow edge seen for TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset:
//  - sync1/sync2/sync3, primed, state=IDLE, settle_cnt, timeout_cnt, q, q_valid, overrun, slow_clk_lost all 0.
//  Edge detect:
//  - rise_det = sync2 & ~sync3 & primed.
//  - primed sets the first cycle sync2==0. This blocks a false edge if slow_clk_in is high at reset release.
//  Timing:
//  - Fast edge k first samples slow_clk_in=1.
//  - rise_det is high in the cycle after edge k+1.
//  - On edge k+2: state goes IDLE->SETTLE and settle_cnt is set to 0.
//  - settle_cnt increments each cycle in SETTLE. On the edge where settle_cnt==SETTLE_CYCLES-1:
//      q<=d_slow, q_valid<=1, state->IDLE.
//  - Capture therefore happens on edge k+2+SETTLE_CYCLES.
//  - Constraint on the integrator: 3+SETTLE_CYCLES < slow half-period measured in fast cycles.
//  FSM:
//  - IDLE:   rise_det -> SETTLE.
//  - SETTLE: count, then capture -> IDLE.
//  - rise_det while in SETTLE (glitch or constraint violation): restart settle_cnt at 0, stay in SETTLE. The pending capture is dropped, so only one capture occurs.
//  Output handshake:
//  - Transfer when q_valid && q_ready. q_valid falls next edge unless a capture happens on the same edge.
//  - Capture while q_valid && !q_ready: q is overwritten with the newest word, q_valid stays 1, overrun<=1.
//  - Capture and transfer on the same edge: new word loaded, q_valid stays 1, no overrun.
//  - q does not change unless a capture occurs.
//  Overrun flag:
//  - overrun clears on clr_overrun.
//  - If clr_overrun and a new overrun occur on the same edge, overrun ends at 1 (set wins).
//  Timeout:
//  - timeout_cnt clears on rise_det and otherwise increments, saturating at TIMEOUT_CYCLES.
//  - slow_clk_lost = (timeout_cnt == TIMEOUT_CYCLES), registered.
//  - slow_clk_lost clears the cycle after the next rise_det.
//  - Width of timeout_cnt is $clog2(TIMEOUT_CYCLES+1).
//  Reset mid-operation: all state returns to reset values immediately, and any pending capture is lost.
// STRUCTURE
//  - Shared package osc_sync_pkg holds typedef enum logic [0:0] {CAP_IDLE, CAP_SETTLE} cap_state_t and SAMPLE_W=12.
//  - Sub-module sync_2ff (1-bit two-flop synchronizer, async reset to 0). This is the natural sub-module and is reusable by other fast-domain receivers.
//  - Edge detect, FSM, output register and timeout counter stay in this module.
// TESTING (fast period 100 ns, slow period 1000 ns, SETTLE_CYCLES=2, TIMEOUT_CYCLES=64)
//  1 Steady stream: d_slow=12'hEFF, 12'hEAE, 12'hAAA, 12'h123 on successive slow edges, q_ready=1
//    -> q shows each value once. q_valid pulses 1 cycle, 4 fast edges after the sampling edge. overrun stays 0.
//  2 Backpressure: q_ready=0 across two slow edges with 12'h0A5 then 12'h15A
//    -> q=12'h15A, q_valid=1, overrun=1. Then clr_overrun=1 for one cycle -> overrun=0.
//  3 Same-edge capture+accept: raise q_ready exactly on the capture edge of the next word
//    -> q updates, q_valid stays 1, overrun=0.
//  4 Reset while slow_clk_in=1 and state=SETTLE
//    -> no capture. No q_valid until after a fall then a rise of slow_clk_in.
//  5 Stop slow_clk_in for 70 fast cycles -> slow_clk_lost=1 by cycle 66. Restart -> slow_clk_lost=0 one cycle after rise_det.
//  6 Glitch: a 2-cycle high pulse on slow_clk_in during SETTLE
//    -> settle restarts, exactly one capture, value taken SETTLE_CYCLES after the glitch edge.

Source files
------------

// File: rtl/osc_sync_pkg.sv
// Types and constants shared by the fast-domain receivers.
package osc_sync_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [0:0] {
    CAP_IDLE   = 1'b0,
    CAP_SETTLE = 1'b1
  } cap_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_d;
  logic sync1_q;
  logic sync2_d;
  logic sync2_q;

  // next-state for the synchronizer chain
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // synchronizer flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/slow_to_fast_capture.sv
// Fast-domain capture of sample words launched on slow_clk rising edges,
// with valid/ready output, sticky overrun and slow-clock-loss detection.
module slow_to_fast_capture
  import osc_sync_pkg::*;
#(
  parameter int WIDTH          = SAMPLE_W,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  input  logic [WIDTH-1:0] d_slow,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  input  logic             clr_overrun,
  output logic             overrun,
  output logic             slow_clk_lost
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_ONE  = SCW'(1);
  localparam logic [SCW-1:0] SETTLE_ZERO = SCW'(0);
  localparam logic [TCW-1:0] TIMEOUT_MAX = TCW'(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TIMEOUT_ONE = TCW'(1);
  localparam logic [TCW-1:0] TIMEOUT_ZRO = TCW'(0);

  logic             sync2;
  logic             sync3_d,       sync3_q;
  logic [1:0]       warm_d,        warm_q;
  logic             primed_d,      primed_q;
  logic             rise_det;
  cap_state_t       state_d,       state_q;
  logic [SCW-1:0]   settle_cnt_d,  settle_cnt_q;
  logic             capture;
  logic [WIDTH-1:0] q_d,           q_q;
  logic             q_valid_d,     q_valid_q;
  logic             overrun_d,     overrun_q;
  logic [TCW-1:0]   timeout_cnt_d, timeout_cnt_q;
  logic             lost_d,        lost_q;

  sync_2ff u_sync (
    .clk (fast_clk),
    .rst (reset),
    .d   (slow_clk_in),
    .q   (sync2)
  );

  // Edge detect. warm_q marks when sync2 holds a real sample rather than its
  // reset value, so a level that is already high at reset release never primes.
  always_comb begin
    sync3_d  = sync2;
    warm_d   = {warm_q[0], 1'b1};
    primed_d = primed_q | (warm_q[1] & ~sync2);
    rise_det = sync2 & ~sync3_q & primed_q;
  end

  // capture FSM: a new edge during settling restarts the wait
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (rise_det) begin
          state_d      = CAP_SETTLE;
          settle_cnt_d = SETTLE_ZERO;
        end else begin
          state_d      = CAP_IDLE;
        end
      end
      CAP_SETTLE: begin
        if (rise_det) begin
          settle_cnt_d = SETTLE_ZERO;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          capture      = 1'b1;
          state_d      = CAP_IDLE;
          settle_cnt_d = SETTLE_ZERO;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_ONE;
        end
      end
      default: begin
        state_d      = CAP_IDLE;
        settle_cnt_d = SETTLE_ZERO;
      end
    endcase
  end

  // output word, handshake and sticky overrun (set beats clear)
  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;
    if (capture) begin
      q_d       = d_slow;
      q_valid_d = 1'b1;
    end else if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end else begin
      q_valid_d = q_valid_q;
    end
    if (capture && q_valid_q && !q_ready) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // saturating slow-clock watchdog
  always_comb begin
    if (rise_det) begin
      timeout_cnt_d = TIMEOUT_ZRO;
    end else if (timeout_cnt_q == TIMEOUT_MAX) begin
      timeout_cnt_d = timeout_cnt_q;
    end else begin
      timeout_cnt_d = timeout_cnt_q + TIMEOUT_ONE;
    end
    lost_d = (timeout_cnt_d == TIMEOUT_MAX);
  end

  // state registers
  always_ff @(posedge fast_clk or posedge reset) begin
    if (reset) begin
      sync3_q       <= 1'b0;
      warm_q        <= 2'b00;
      primed_q      <= 1'b0;
      state_q       <= CAP_IDLE;
      settle_cnt_q  <= SETTLE_ZERO;
      q_q           <= {WIDTH{1'b0}};
      q_valid_q     <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_cnt_q <= TIMEOUT_ZRO;
      lost_q        <= 1'b0;
    end else begin
      sync3_q       <= sync3_d;
      warm_q        <= warm_d;
      primed_q      <= primed_d;
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      q_q           <= q_d;
      q_valid_q     <= q_valid_d;
      overrun_q     <= overrun_d;
      timeout_cnt_q <= timeout_cnt_d;
      lost_q        <= lost_d;
    end
  end

  assign q             = q_q;
  assign q_valid       = q_valid_q;
  assign overrun       = overrun_q;
  assign slow_clk_lost = lost_q;

endmodule

// File: tb/tb_slow_to_fast_capture.sv
// Randomized and directed bench for slow_to_fast_capture against an
// edge-count based reference model.
module tb_slow_to_fast_capture;

  localparam int W = 12;
  localparam int S = 2;
  localparam int T = 64;

  logic         fast_clk = 1'b0;
  logic         reset;
  logic         slow_clk_in;
  logic [W-1:0] d_slow;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         clr_overrun;
  logic         overrun;
  logic         slow_clk_lost;

  always #50 fast_clk = ~fast_clk;

  slow_to_fast_capture #(
    .WIDTH          (W),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .fast_clk      (fast_clk),
    .reset         (reset),
    .slow_clk_in   (slow_clk_in),
    .d_slow        (d_slow),
    .q             (q),
    .q_valid       (q_valid),
    .q_ready       (q_ready),
    .clr_overrun   (clr_overrun),
    .overrun       (overrun),
    .slow_clk_lost (slow_clk_lost)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges are numbered from 1 after reset release. A slow
  // rise is the first edge that samples 1 after an edge (numbered >=1) that
  // sampled 0; the word is taken S+2 edges later unless another rise occurs
  // at most S edges after it. The watchdog restarts 2 edges after a rise.
  int           n;
  int           last_clear;
  int           clr_pend;
  int           capq[$];
  logic         prev_level;
  logic [W-1:0] q_m;
  logic         qv_m;
  logic         ov_m;
  logic         lost_m;

  function automatic logic [W-1:0] z1(input logic b);
    logic [W-1:0] r;
    r = '0;
    r[0] = b;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n          = 0;
    last_clear = 0;
    clr_pend   = -1;
    capq.delete();
    prev_level = 1'b0;
    q_m        = '0;
    qv_m       = 1'b0;
    ov_m       = 1'b0;
    lost_m     = 1'b0;
  endtask

  task automatic model_step();
    logic xfer;
    logic cap;
    int   keep[$];
    n++;
    xfer = qv_m && q_ready;
    cap  = 1'b0;
    if (capq.size() > 0 && capq[0] == n) begin
      cap = 1'b1;
      void'(capq.pop_front());
    end
    if (clr_pend == n) last_clear = n;
    if (n >= 2 && slow_clk_in && !prev_level) begin
      keep.delete();
      foreach (capq[i]) if (capq[i] < n + 2) keep.push_back(capq[i]);
      capq = keep;
      capq.push_back(n + 2 + S);
      clr_pend = n + 2;
    end
    prev_level = slow_clk_in;
    if (cap && qv_m && !q_ready) ov_m = 1'b1;
    else if (clr_overrun)        ov_m = 1'b0;
    if (cap) begin
      q_m  = d_slow;
      qv_m = 1'b1;
    end else if (xfer) begin
      qv_m = 1'b0;
    end
    lost_m = ((n - last_clear) >= T);
  endtask

  task automatic check_outputs();
    check_eq("q",        q,                  q_m);
    check_eq("q_valid",  z1(q_valid),        z1(qv_m));
    check_eq("overrun",  z1(overrun),        z1(ov_m));
    check_eq("clk_lost", z1(slow_clk_lost),  z1(lost_m));
  endtask

  task automatic cycle();
    @(posedge fast_clk);
    if (!reset) model_step();
    @(negedge fast_clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic slow_period(input logic [W-1:0] val, input int hi, input int lo);
    slow_clk_in = 1'b1;
    d_slow      = val;
    repeat (hi) cycle();
    slow_clk_in = 1'b0;
    repeat (lo) cycle();
  endtask

  initial begin
    int pulses;
    reset       = 1'b1;
    slow_clk_in = 1'b0;
    d_slow      = '0;
    q_ready     = 1'b1;
    clr_overrun = 1'b0;
    model_reset();
    @(negedge fast_clk);
    do_reset();
    repeat (3) cycle();

    // 1: steady stream
    slow_period(12'hEFF, 5, 5);
    slow_period(12'hEAE, 5, 5);
    slow_period(12'hAAA, 5, 5);
    slow_period(12'h123, 5, 5);
    check_eq("t1_q_last",  q,           12'h123);
    check_eq("t1_overrun", z1(overrun), 12'h000);

    // 2: backpressure then clear
    q_ready = 1'b0;
    slow_period(12'h0A5, 5, 5);
    slow_period(12'h15A, 5, 5);
    check_eq("t2_q",       q,           12'h15A);
    check_eq("t2_valid",   z1(q_valid), 12'h001);
    check_eq("t2_overrun", z1(overrun), 12'h001);
    clr_overrun = 1'b1;
    cycle();
    clr_overrun = 1'b0;
    check_eq("t2_clr",     z1(overrun), 12'h000);

    // 3: accept on the capture edge of the next word
    slow_clk_in = 1'b1;
    d_slow      = 12'h3C3;
    repeat (4) cycle();
    q_ready = 1'b1;
    cycle();
    q_ready = 1'b0;
    check_eq("t3_q",       q,           12'h3C3);
    check_eq("t3_valid",   z1(q_valid), 12'h001);
    check_eq("t3_overrun", z1(overrun), 12'h000);
    slow_clk_in = 1'b0;
    q_ready     = 1'b1;
    repeat (5) cycle();

    // 4: reset while high and settling
    slow_clk_in = 1'b1;
    d_slow      = 12'h7E7;
    repeat (3) cycle();
    do_reset();
    pulses = 0;
    repeat (8) begin
      cycle();
      pulses += int'(q_valid);
    end
    check_eq("t4_no_cap", 12'(pulses), 12'h000);
    slow_clk_in = 1'b0;
    repeat (5) cycle();
    slow_period(12'h456, 5, 5);
    check_eq("t4_recap", q, 12'h456);

    // 5: slow clock stops, then restarts
    slow_clk_in = 1'b0;
    repeat (70) cycle();
    check_eq("t5_lost", z1(slow_clk_lost), 12'h001);
    slow_clk_in = 1'b1;
    d_slow      = 12'h5A5;
    cycle();
    cycle();
    check_eq("t5_lost_hold", z1(slow_clk_lost), 12'h001);
    cycle();
    check_eq("t5_lost_clr",  z1(slow_clk_lost), 12'h000);
    repeat (2) cycle();
    slow_clk_in = 1'b0;
    repeat (5) cycle();

    // 6: glitch during settling
    q_ready     = 1'b1;
    pulses      = 0;
    slow_clk_in = 1'b1;
    d_slow      = 12'h111;
    cycle();
    pulses += int'(q_valid);
    slow_clk_in = 1'b0;
    cycle();
    pulses += int'(q_valid);
    slow_clk_in = 1'b1;
    d_slow      = 12'h222;
    repeat (2) begin
      cycle();
      pulses += int'(q_valid);
    end
    slow_clk_in = 1'b0;
    repeat (8) begin
      cycle();
      pulses += int'(q_valid);
    end
    check_eq("t6_one_cap", 12'(pulses), 12'h001);
    check_eq("t6_q",       q,           12'h222);

    // random waveforms, handshake and clears
    for (int seg = 0; seg < 120; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if (lvl && !slow_clk_in) d_slow = 12'($urandom);
      slow_clk_in = lvl;
      for (int c = 0; c < len; c++) begin
        q_ready     = 1'($urandom_range(0, 1));
        clr_overrun = ($urandom_range(0, 9) == 0);
        cycle();
      end
      if (seg == 60) do_reset();
    end
    clr_overrun = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
